// File: rtl/mem_reinit_pkg.sv
// Shared types and defaults for the BRAM reinit/readback blocks.
package mem_reinit_pkg;

  localparam int unsigned DefDepthMem = 32768;
  localparam int unsigned DefWidMem   = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding captured read words ({last, addr, data}) ahead of the stream port.
module rd_skid_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [Width-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mem_dump_reader.sv
// Sweeps an address window of a 1-cycle-latency BRAM and streams the words out with backpressure.
// Optional: define DUMP_CHECKSUM_EN to add a 16-bit running checksum output of delivered words.
module mem_dump_reader
  import mem_reinit_pkg::*;
#(
  parameter int unsigned WID_MEM   = DefWidMem,
  parameter int unsigned DEPTH_MEM = DefDepthMem,
  localparam int unsigned ADDR_W   = addr_width(DEPTH_MEM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] raddr,
  input  logic [WID_MEM-1:0] rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned FifoW = 1 + ADDR_W + WID_MEM;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [ADDR_W-1:0] r_raddr;

  logic [1:0]        w_fifo_count;
  logic [FifoW-1:0]  w_fifo_head;
  logic              w_pop;
  logic [2:0]        w_occupancy;
  logic              w_issue;
  logic [ADDR_W-1:0] w_next_addr_inc;

  assign m_valid = (w_fifo_count != 2'd0);
  assign w_pop   = m_valid && m_ready;

  // Words that will occupy the buffer after this cycle: buffered + arriving - leaving.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == StRun) && (r_remaining != '0) && (w_occupancy < 3'd2);

  assign w_next_addr_inc = (r_next_addr == LastAddr) ? '0 : r_next_addr + ADDR_W'(1);

  // The issuing address reaches memory in the issue cycle; otherwise the last one is held.
  assign raddr = w_issue ? r_next_addr : r_raddr;

  // Control FSM: window capture, read sequencing, drain and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_next_addr <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (len != '0) begin
              r_state     <= StRun;
              r_next_addr <= start_addr;
              r_remaining <= len;
              r_busy      <= 1'b1;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_issue) begin
            r_next_addr <= w_next_addr_inc;
            r_remaining <= r_remaining - LenOne;
          end else if (r_remaining == '0) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if ((w_fifo_count == 2'd0) && !r_inflight) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // In-flight read tracking: remembers address and last flag for the word arriving next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_raddr         <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_raddr         <= r_next_addr;
        r_inflight_last <= (r_remaining == LenOne);
      end
    end
  end

  rd_skid_fifo #(
    .Width (FifoW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, r_raddr, rdata}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign {m_last, m_addr, m_data} = w_fifo_head;
  assign busy = r_busy;
  assign done = r_done;

`ifdef DUMP_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running 16-bit sum of delivered words, restarted on each accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + 16'(m_data);
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed + randomized bench for mem_dump_reader against a window/queue reference model.
module tb_mem_dump_reader;

  localparam int Wid   = 8;
  localparam int Depth = 32768;
  localparam int Aw    = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [Aw-1:0]  start_addr;
  logic [Aw:0]    len;
  logic [Aw-1:0]  raddr;
  logic [Wid-1:0] rdata;
  logic           m_valid;
  logic           m_ready;
  logic [Wid-1:0] m_data;
  logic [Aw-1:0]  m_addr;
  logic           m_last;
  logic           busy;
  logic           done;
`ifdef DUMP_CHECKSUM_EN
  logic [15:0]    checksum;
`endif

  logic [Wid-1:0] mem [Depth];

  int total = 0;
  int bad   = 0;

  mem_dump_reader #(
    .WID_MEM   (Wid),
    .DEPTH_MEM (Depth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .raddr      (raddr),
    .rdata      (rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_last     (m_last),
    .busy       (busy),
`ifdef DUMP_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, one cycle latency.
  always @(posedge clk) rdata <= mem[raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_pattern(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc >= 10 && cyc <= 14) ? 1'b0 : logic'(cyc % 2);
    return ($urandom % 4) != 0;
  endfunction

  // Run one window; mode selects the m_ready pattern; stray_cyc (>0) fires an extra start mid-run.
  task automatic run_window(input int sa, input int ln, input int mode, input int stray_cyc);
    int q_addr[$];
    int q_data[$];
    int q_last[$];
    int sum = 0;
    int first_valid = -1;
    int last_hs = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int beats = 0;
    int finished = 0;
    int budget = 20 * ln + 40;
    logic prev_stall = 1'b0;
    logic [Wid-1:0] prev_data = '0;
    logic [Aw-1:0] prev_addr = '0;
    logic prev_last = 1'b0;
    for (int i = 0; i < ln; i++) begin
      int a = (sa + i) % Depth;
      q_addr.push_back(a);
      q_data.push_back(int'(mem[a]));
      q_last.push_back((i == ln - 1) ? 1 : 0);
      sum += int'(mem[a]);
    end
    @(negedge clk);
    start = 1'b1;
    start_addr = Aw'(sa);
    len = (Aw + 1)'(ln);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == stray_cyc) begin
        start = 1'b1;
        start_addr = Aw'(7000);
        len = (Aw + 1)'(4);
      end
      m_ready = ready_pattern(mode, cyc);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_addr", 32'(m_addr), 32'(prev_addr));
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk("busy", 32'(busy), 32'((ln != 0) && (done_cnt == 0)));
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        if (q_addr.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("beat_addr", 32'(m_addr), 32'(q_addr.pop_front()));
          chk("beat_data", 32'(m_data), 32'(q_data.pop_front()));
          chk("beat_last", 32'(m_last), 32'(q_last.pop_front()));
        end
        beats++;
        last_hs = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_addr = m_addr;
      prev_last = m_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        finished = 1;
        break;
      end
    end
    chk("finished", 32'(finished), 1);
    chk("beat_count", 32'(beats), 32'(ln));
    chk("done_count", 32'(done_cnt), 1);
    if (ln == 0) begin
      chk("len0_done_cyc", 32'(done_cyc), 1);
      chk("len0_no_valid", 32'(first_valid), 32'(-1));
    end else begin
      // done rises on the edge one cycle after the last handshake edge.
      chk("done_after_last", 32'(done_cyc), 32'(last_hs + 2));
      if (mode == 0) begin
        // First word appears two edges after the start edge, then one per cycle.
        chk("first_latency", 32'(first_valid), 3);
        chk("throughput", 32'(last_hs), 32'(ln + 2));
      end
    end
`ifdef DUMP_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(sum & 16'hFFFF));
`else
    if (sum < 0) chk("sum_sign", 32'(sum), 0);
`endif
  endtask

  initial begin
    int hs;
    int done_seen;
    reset = 1'b0;
    start = 1'b0;
    start_addr = '0;
    len = '0;
    m_ready = 1'b0;
    for (int i = 0; i < Depth; i++) mem[i] = Wid'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b1;
    @(negedge clk);

    // Data equal to addr[0] over a window at the bottom of memory.
    for (int i = 0; i < 8; i++) mem[i] = Wid'(i % 2);
    run_window(0, 8, 0, -1);
    // Window crossing the top of memory.
    run_window(32766, 4, 0, -1);
    // Alternating ready with a five-cycle stall.
    run_window(1234, 16, 1, -1);
    // Empty window, then a start while busy that must be ignored.
    run_window(50, 0, 0, -1);
    run_window(40, 4, 0, 2);

    // Reset in the middle of a window.
    @(negedge clk);
    start = 1'b1;
    start_addr = Aw'(100);
    len = (Aw + 1)'(10);
    m_ready = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 40 && hs < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) hs++;
    end
    chk("mid_hs", 32'(hs), 3);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_raddr", 32'(raddr), 0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done || m_valid) done_seen++;
    end
    chk("midrst_quiet", 32'(done_seen), 0);
    run_window(500, 6, 0, -1);

    // Checksum example words.
    mem[200] = 8'h10;
    mem[201] = 8'h20;
    mem[202] = 8'hF0;
    mem[203] = 8'hFF;
    run_window(200, 4, 2, -1);
`ifdef DUMP_CHECKSUM_EN
    chk("checksum_021f", 32'(checksum), 32'h021F);
`endif

    // Randomized windows under random backpressure.
    for (int r = 0; r < 6; r++) begin
      run_window(int'($urandom % Depth), 1 + int'($urandom % 30), 2, -1);
    end
    run_window(Depth - 5, 12, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Read-side companion to the block-RAM memory wrapper: it drives the memory's raddr and consumes its dout (1-cycle registered read latency).
- It sweeps a programmable address window and streams each word out on a valid/ready interface with full backpressure.
- Used to read back and verify reinitialised BRAM contents, word by word, in address order.

Parameters:
- WID_MEM, 1, width of one memory word and of m_data.
- DEPTH_MEM, 32768, number of memory words; ADDR_W = $clog2(DEPTH_MEM), 15 at default.

Ports:
- clk  in  1  single clock; all logic posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; latches start_addr/len when idle.
- start_addr  in  ADDR_W  first word address of the window.
- len  in  ADDR_W+1  number of words to read, 0..DEPTH_MEM.
- raddr  out  ADDR_W  read address to memory.
- rdata  in  WID_MEM  memory dout, valid one cycle after raddr is sampled.
- m_valid  out  1  output word available.
- m_ready  in  1  downstream accepts word.
- m_data  out  WID_MEM  output word.
- m_addr  out  ADDR_W  address the m_data word came from.
- m_last  out  1  marks the final word of the window.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word handshake.

Behaviour:
- Reset values: raddr=0, m_valid=0, m_data=0, m_addr=0, m_last=0, busy=0, done=0; FSM enters IDLE; buffer is emptied.
- FSM states:
  - IDLE: start with len>0 → RUN; captures next_addr=start_addr and remaining=len, sets busy=1.
  - start with len==0 → DONE; busy stays 0.
  - start while busy is ignored.
  - RUN: issue reads until remaining==0 → DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight → DONE.
  - DONE: done=1 for exactly one cycle → IDLE; busy falls in the same cycle.
- Read issue: a read is issued in a cycle when remaining>0 and (buf_count + inflight − pop) < 2.
  - raddr=next_addr; inflight is set for one cycle.
  - next_addr increments; remaining decrements.
- Wrap-around: next_addr DEPTH_MEM−1 → 0. A window may cross the top of memory.
- Capture: the cycle after an issue, rdata is pushed into the 2-entry buffer together with its address and its last flag (remaining was 1 at issue).
- Output: m_valid = buffer not empty. m_data, m_addr and m_last come from the buffer head. Pop happens on m_valid && m_ready.
- Ordering: strictly in address order. No word is lost or duplicated under any m_ready pattern.
- Throughput: with m_ready held high, one word per cycle after 2 cycles of initial latency (start → first m_valid).
- m_valid/m_data stability: once m_valid is high, m_data, m_addr and m_last hold until the handshake.
- Simultaneous push and pop: both succeed in the same cycle and the count is unchanged.
- Reset mid-operation: everything aborts immediately to the reset values; no done pulse.
- raddr holds its last value when no read is issued. The memory write port is not touched by this block.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- When defined: adds output checksum [15:0], holding the 16-bit wrapping sum of zero-extended m_data over every handshake in the current window.
  - Cleared on accepted start, and on reset.
  - Value is final when done pulses; held until the next start.
- When undefined: no checksum port and no checksum logic.

Decomposition:
- Shared package mem_reinit_pkg holds:
  - the FSM state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the default DEPTH_MEM/WID_MEM constants;
  - the address-width function.
- One sub-module, rd_skid_fifo: a 2-entry FIFO storing {last, addr, data}, with push/pop/count and parameterised width.

Test Plan:
- Memory preloaded with data=addr[0]; start_addr=0, len=8, m_ready=1 → 8 consecutive beats, m_addr 0..7, m_data 0,1,0,1..., m_last on addr 7, done one cycle after that handshake.
- start_addr=32766, len=4 → m_addr sequence 32766, 32767, 0, 1; m_last on addr 1.
- len=16 with m_ready toggling 1010… and a 5-cycle low stall mid-stream → all 16 words delivered in order; m_data stable while stalled; no more than 2 words buffered.
- len=0 start → done pulses once, no m_valid, busy never rises. A second start while busy with len=4 is ignored.
- reset driven low at word 3 of 10 → m_valid=0 and busy=0 immediately; no done pulse. A new start after release runs from the new start_addr.
- With DUMP_CHECKSUM_EN, WID_MEM=8, words 0x10,0x20,0xF0,0xFF → checksum 0x021F at done.
